// File: rtl/eco32f_fetch.sv
// eco32f instruction fetch stage.
// Owns the program counter and keeps at most one instruction-bus request
// outstanding. Delivers instructions to decode, parks a word in a one-entry
// skid buffer when decode cannot take it, redirects on execute's request,
// and feeds NOPs to decode whenever no valid instruction is available.
//
// Handshake: a request is presented while ibus_req_o is high and holds a
// stable ibus_adr_o until the cycle in which ibus_ack_i or ibus_err_i is
// seen (which may be the cycle the request is raised). Decode accepts new
// ID values only in cycles where id_stall and id_bubble are both low; a
// redirect overrides that and always loads ID.
module eco32f_fetch #(
  parameter logic [31:0] RESET_PC = 32'he000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] ibus_adr_o,
  output logic        ibus_req_o,
  input  logic [31:0] ibus_dat_i,
  input  logic        ibus_ack_i,
  input  logic        ibus_err_i,
  input  logic        id_stall,
  input  logic        id_bubble,
  input  logic        ex_branch_taken,
  input  logic [31:0] ex_branch_target,
  output logic [31:0] id_pc,
  output logic [31:0] id_insn,
  output logic        id_exc_ibus_fault
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [31:0] NOP = 32'h0000_0000;

  state_t      state;
  logic [31:0] fetch_pc;
  // Address of the old-path request still on the bus while draining;
  // fetch_pc already points at the redirect target during that time.
  logic [31:0] drain_pc;
  logic [31:0] buf_insn;
  logic [31:0] buf_pc;
  logic        buf_err;

  logic        adv;
  logic        done;
  logic [31:0] target;

  assign adv    = !id_stall && !id_bubble;
  assign done   = ibus_ack_i || ibus_err_i;
  assign target = ex_branch_target & 32'hffff_fffc;

  assign ibus_adr_o = (state == DRAIN) ? drain_pc : fetch_pc;
  assign ibus_req_o = (state == FETCH) || (state == DRAIN);

  // Fetch FSM, PC, skid buffer and ID output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state             <= IDLE;
      fetch_pc          <= {RESET_PC[31:2], 2'b00};
      drain_pc          <= 32'h0;
      buf_insn          <= 32'h0;
      buf_pc            <= 32'h0;
      buf_err           <= 1'b0;
      id_insn           <= 32'h0;
      id_pc             <= 32'h0;
      id_exc_ibus_fault <= 1'b0;
    end else if (ex_branch_taken) begin
      // Redirect wins over back-pressure; anything arriving now is dropped.
      id_insn           <= NOP;
      id_pc             <= target;
      id_exc_ibus_fault <= 1'b0;
      fetch_pc          <= target;
      buf_insn          <= 32'h0;
      buf_pc            <= 32'h0;
      buf_err           <= 1'b0;
      if (state == FETCH && !done) begin
        state    <= DRAIN;
        drain_pc <= fetch_pc;
      end else if (state == DRAIN) begin
        state <= DRAIN;
      end else begin
        state <= FETCH;
      end
    end else begin
      unique case (state)
        IDLE: begin
          state <= FETCH;
        end
        FETCH: begin
          if (done) begin
            fetch_pc <= fetch_pc + 32'd4;
            if (adv) begin
              id_insn           <= ibus_err_i ? NOP : ibus_dat_i;
              id_pc             <= fetch_pc;
              id_exc_ibus_fault <= ibus_err_i;
              state             <= ibus_err_i ? HALT : FETCH;
            end else begin
              buf_insn <= ibus_err_i ? NOP : ibus_dat_i;
              buf_pc   <= fetch_pc;
              buf_err  <= ibus_err_i;
              state    <= HOLD;
            end
          end else if (adv) begin
            id_insn           <= NOP;
            id_pc             <= fetch_pc;
            id_exc_ibus_fault <= 1'b0;
          end
        end
        HOLD: begin
          if (adv) begin
            id_insn           <= buf_insn;
            id_pc             <= buf_pc;
            id_exc_ibus_fault <= buf_err;
            state             <= buf_err ? HALT : FETCH;
          end
        end
        DRAIN: begin
          if (adv) begin
            id_insn           <= NOP;
            id_pc             <= fetch_pc;
            id_exc_ibus_fault <= 1'b0;
          end
          if (done) begin
            state <= FETCH;
          end
        end
        HALT: begin
          if (adv) begin
            id_insn           <= NOP;
            id_pc             <= fetch_pc;
            id_exc_ibus_fault <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eco32f_fetch.sv
// Bench for eco32f_fetch: a wait-state bus slave, directed scenarios with
// literal expectations, and a per-cycle reference model of the ID stream.
module tb_eco32f_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] ibus_adr_o;
  logic        ibus_req_o;
  logic [31:0] ibus_dat_i;
  logic        ibus_ack_i;
  logic        ibus_err_i;
  logic        id_stall = 1'b0;
  logic        id_bubble = 1'b0;
  logic        ex_branch_taken = 1'b0;
  logic [31:0] ex_branch_target = 32'h0;
  logic [31:0] id_pc;
  logic [31:0] id_insn;
  logic        id_exc_ibus_fault;

  int n_vec = 0;
  int n_err = 0;

  eco32f_fetch #(.RESET_PC(32'he000_0000)) dut (
    .clk               (clk),
    .rst               (rst),
    .ibus_adr_o        (ibus_adr_o),
    .ibus_req_o        (ibus_req_o),
    .ibus_dat_i        (ibus_dat_i),
    .ibus_ack_i        (ibus_ack_i),
    .ibus_err_i        (ibus_err_i),
    .id_stall          (id_stall),
    .id_bubble         (id_bubble),
    .ex_branch_taken   (ex_branch_taken),
    .ex_branch_target  (ex_branch_target),
    .id_pc             (id_pc),
    .id_insn           (id_insn),
    .id_exc_ibus_fault (id_exc_ibus_fault)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bus slave ----------------
  // Memory word at address a is a ^ 32'h1234_5678. Acks after ws wait
  // cycles; answers with an error instead when the address is err_addr.
  logic [31:0] ws = 32'd0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  logic [31:0] wait_cnt;
  logic        ready;
  logic        hit;

  always @(posedge clk or negedge rst) begin
    if (!rst) wait_cnt <= 32'd0;
    else if (ibus_req_o && !(ibus_ack_i || ibus_err_i)) wait_cnt <= wait_cnt + 32'd1;
    else wait_cnt <= 32'd0;
  end

  always_comb begin
    hit        = err_en && (ibus_adr_o == err_addr);
    ready      = ibus_req_o && (wait_cnt >= ws);
    ibus_ack_i = ready && !hit;
    ibus_err_i = ready && hit;
    ibus_dat_i = ibus_adr_o ^ 32'h1234_5678;
  end

  // ---------------- check helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Tracks: whether fetching has started, whether fetching is halted by a
  // fault, whether an abandoned request is still on the bus, the next fetch
  // address, and a queue of fetched words not yet handed to decode.
  logic        m_live, m_halt, m_drain;
  logic [31:0] m_pc, m_drain_adr;
  logic [64:0] exp_q[$];
  logic [31:0] e_insn, e_pc;
  logic        e_fault;
  logic        exp_req, m_adv, m_done;
  logic [31:0] exp_adr, m_tgt;
  logic [64:0] w;

  always @(negedge clk) begin
    if (!rst) begin
      m_live = 1'b0; m_halt = 1'b0; m_drain = 1'b0;
      m_pc = 32'he000_0000; m_drain_adr = 32'h0;
      exp_q.delete();
      e_insn = 32'h0; e_pc = 32'h0; e_fault = 1'b0;
    end
    exp_req = m_live && !m_halt && (exp_q.size() == 0);
    exp_adr = m_drain ? m_drain_adr : m_pc;
    chk("req", 32'(ibus_req_o), 32'(exp_req));
    if (exp_req) chk("adr", ibus_adr_o, exp_adr);
    chk("id_insn", id_insn, e_insn);
    chk("id_pc", id_pc, e_pc);
    chk("id_fault", 32'(id_exc_ibus_fault), 32'(e_fault));
    if (rst) begin
      m_adv  = !id_stall && !id_bubble;
      m_done = exp_req && (ibus_ack_i || ibus_err_i);
      if (ex_branch_taken) begin
        m_tgt = ex_branch_target & 32'hffff_fffc;
        e_insn = 32'h0; e_pc = m_tgt; e_fault = 1'b0;
        if (!m_drain && exp_req && !m_done) begin
          m_drain = 1'b1;
          m_drain_adr = m_pc;
        end
        m_pc = m_tgt; m_halt = 1'b0; m_live = 1'b1;
        exp_q.delete();
      end else if (!m_live) begin
        m_live = 1'b1;
      end else if (m_drain) begin
        if (m_adv) begin e_insn = 32'h0; e_pc = m_pc; e_fault = 1'b0; end
        if (m_done) m_drain = 1'b0;
      end else if (m_halt) begin
        if (m_adv) begin e_insn = 32'h0; e_pc = m_pc; e_fault = 1'b0; end
      end else if (exp_q.size() != 0) begin
        if (m_adv) begin
          w = exp_q.pop_front();
          e_insn = w[64:33]; e_pc = w[32:1]; e_fault = w[0];
          m_halt = w[0];
        end
      end else if (m_done) begin
        w = ibus_err_i ? {32'h0, m_pc, 1'b1} : {ibus_dat_i, m_pc, 1'b0};
        m_pc = m_pc + 32'd4;
        if (m_adv) begin
          e_insn = w[64:33]; e_pc = w[32:1]; e_fault = w[0];
          m_halt = w[0];
        end else begin
          exp_q.push_back(w);
        end
      end else if (m_adv) begin
        e_insn = 32'h0; e_pc = m_pc; e_fault = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the first post-reset cycle (DUT in IDLE).
  task automatic do_reset();
    rst = 1'b0;
    id_stall = 1'b0; id_bubble = 1'b0;
    ex_branch_taken = 1'b0; ex_branch_target = 32'h0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    // Zero-wait bus: one instruction per cycle from RESET_PC.
    ws = 32'd0;
    do_reset();
    tick();
    chk("s1_first_req", 32'(ibus_req_o), 32'd1);
    chk("s1_first_adr", ibus_adr_o, 32'he000_0000);
    tick();
    chk("s1_pc0", id_pc, 32'he000_0000);
    chk("s1_insn0", id_insn, 32'hf234_5678);
    tick();
    chk("s1_pc1", id_pc, 32'he000_0004);
    chk("s1_insn1", id_insn, 32'hf234_567c);
    tick();
    chk("s1_pc2", id_pc, 32'he000_0008);
    chk("s1_insn2", id_insn, 32'hf234_5670);

    // One wait state: instruction, NOP, instruction.
    ws = 32'd1;
    do_reset();
    tick(); tick(); tick();
    chk("s2_insn0", id_insn, 32'hf234_5678);
    chk("s2_pc0", id_pc, 32'he000_0000);
    tick();
    chk("s2_nop", id_insn, 32'h0);
    tick();
    chk("s2_insn1", id_insn, 32'hf234_567c);
    chk("s2_pc1", id_pc, 32'he000_0004);

    // Stall for three cycles while e0000008 is acked into the buffer.
    ws = 32'd0;
    do_reset();
    tick(); tick(); tick();
    id_stall = 1'b1;
    tick();
    chk("s3_req_drop", 32'(ibus_req_o), 32'd0);
    chk("s3_hold_a", id_pc, 32'he000_0004);
    tick();
    chk("s3_hold_b", id_pc, 32'he000_0004);
    tick();
    id_stall = 1'b0;
    chk("s3_hold_c", id_pc, 32'he000_0004);
    tick();
    chk("s3_buf_pc", id_pc, 32'he000_0008);
    chk("s3_buf_insn", id_insn, 32'hf234_5670);
    tick();
    chk("s3_next_pc", id_pc, 32'he000_000c);
    chk("s3_next_insn", id_insn, 32'hf234_5674);

    // Redirect to 00001002 while the first request waits for its ack.
    ws = 32'd2;
    do_reset();
    tick();
    ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_1002;
    tick();
    ex_branch_taken = 1'b0;
    chk("s4_nop", id_insn, 32'h0);
    chk("s4_nop_pc", id_pc, 32'h0000_1000);
    chk("s4_old_adr_a", ibus_adr_o, 32'he000_0000);
    tick();
    chk("s4_old_adr_b", ibus_adr_o, 32'he000_0000);
    tick();
    chk("s4_new_req", 32'(ibus_req_o), 32'd1);
    chk("s4_new_adr", ibus_adr_o, 32'h0000_1000);
    tick(); tick(); tick();
    chk("s4_tgt_insn", id_insn, 32'h1234_4678);
    chk("s4_tgt_pc", id_pc, 32'h0000_1000);

    // Bus error on e0000004, halt, then resume at e0000008 by redirect.
    ws = 32'd0; err_en = 1'b1; err_addr = 32'he000_0004;
    do_reset();
    tick(); tick(); tick();
    chk("s5_fault", 32'(id_exc_ibus_fault), 32'd1);
    chk("s5_fault_insn", id_insn, 32'h0);
    chk("s5_fault_pc", id_pc, 32'he000_0004);
    tick();
    chk("s5_halt_a", 32'(ibus_req_o), 32'd0);
    tick();
    chk("s5_halt_b", 32'(ibus_req_o), 32'd0);
    tick();
    ex_branch_taken = 1'b1; ex_branch_target = 32'he000_0008;
    tick();
    ex_branch_taken = 1'b0;
    chk("s5_resume_req", 32'(ibus_req_o), 32'd1);
    chk("s5_resume_adr", ibus_adr_o, 32'he000_0008);
    tick();
    chk("s5_resume_insn", id_insn, 32'hf234_5670);
    chk("s5_resume_pc", id_pc, 32'he000_0008);
    err_en = 1'b0;

    // PC wrap-around through a bubble into the skid buffer.
    ws = 32'd0;
    do_reset();
    tick();
    ex_branch_taken = 1'b1; ex_branch_target = 32'hffff_ffff;
    tick();
    ex_branch_taken = 1'b0;
    chk("s6_tgt_adr", ibus_adr_o, 32'hffff_fffc);
    chk("s6_nop_pc", id_pc, 32'hffff_fffc);
    tick();
    id_bubble = 1'b1;
    chk("s6_top_pc", id_pc, 32'hffff_fffc);
    chk("s6_top_insn", id_insn, 32'hedcb_a984);
    chk("s6_wrap_adr", ibus_adr_o, 32'h0000_0000);
    tick();
    id_bubble = 1'b0;
    chk("s6_bubble_hold", id_pc, 32'hffff_fffc);
    tick();
    chk("s6_wrap_pc", id_pc, 32'h0000_0000);
    chk("s6_wrap_insn", id_insn, 32'h1234_5678);

    // Asynchronous reset during a wait: request drops at once.
    ws = 32'd3;
    do_reset();
    tick(); tick();
    chk("s7_req_before", 32'(ibus_req_o), 32'd1);
    rst = 1'b0;
    #1;
    chk("s7_req_async_drop", 32'(ibus_req_o), 32'd0);
    ws = 32'd0;
    do_reset();
    tick();
    chk("s7_restart_adr", ibus_adr_o, 32'he000_0000);
    chk("s7_restart_req", 32'(ibus_req_o), 32'd1);
    tick();
    chk("s7_restart_pc", id_pc, 32'he000_0000);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
